fetch_redirect_unit: RTL and testbench

- Consumer end of the branch-resolution interface. Takes `shouldBranch`/`branchTarget` from the execute-stage branch logic and owns the fetch program counter.
- Applies redirects and holds any redirect that arrives during a pipeline stall until the stall clears.
- Issues flushes to the IF/ID and ID/EX pipeline registers, suppresses fetch-valid for a configurable number of bubble cycles after a redirect, and counts redirects.
- Sits between the branch unit / hazard unit and the instruction-memory address port.

---
 rtl/fetch_redirect_unit.sv | 79 +++++++
 tb/tb_fetch_redirect_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: owns the fetch PC, applies branch redirects, defers
// redirects that arrive during a stall, flushes the front-end pipeline
// registers, inserts fetch bubbles after a redirect and counts redirects.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          INSTR_BYTES   = 4,
  parameter int          BUBBLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        shouldBranch,
  input  logic [31:0] branchTarget,
  output logic [31:0] programCounter,
  output logic        fetchValid,
  output logic        flushDecode,
  output logic        flushExecute,
  output logic        redirectPending,
  output logic        misalignedTarget,
  output logic [31:0] redirectCount
);

  localparam logic [3:0]  BUBBLE_LOAD = 4'(BUBBLE_CYCLES);
  localparam logic [31:0] PC_STEP     = 32'(INSTR_BYTES);

  logic [31:0] pendingTarget;
  logic [3:0]  bubbleCnt;
  logic        reqActive;
  logic [31:0] reqTarget;
  logic        applyRedirect;

  // A live request always wins over a held one; a redirect can only land
  // on a cycle where the hazard unit lets the front end advance.
  always_comb begin
    reqActive     = shouldBranch | redirectPending;
    reqTarget     = shouldBranch ? branchTarget : pendingTarget;
    applyRedirect = reqActive & ~stall;
    flushDecode   = applyRedirect;
    flushExecute  = applyRedirect;
  end

  // PC, deferred-redirect, bubble-counter and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      programCounter   <= RESET_PC;
      pendingTarget    <= 32'h0;
      redirectPending  <= 1'b0;
      fetchValid       <= 1'b0;
      misalignedTarget <= 1'b0;
      bubbleCnt        <= 4'h0;
      redirectCount    <= 32'h0;
    end else if (applyRedirect) begin
      programCounter   <= {reqTarget[31:2], 2'b00};
      misalignedTarget <= |reqTarget[1:0];
      redirectPending  <= 1'b0;
      redirectCount    <= redirectCount + 32'd1;
      bubbleCnt        <= BUBBLE_LOAD;
      fetchValid       <= 1'b0;
    end else begin
      misalignedTarget <= 1'b0;
      if (stall) begin
        // Everything freezes; a branch seen now is held (newest wins).
        if (shouldBranch) begin
          pendingTarget   <= branchTarget;
          redirectPending <= 1'b1;
        end
      end else begin
        programCounter <= programCounter + PC_STEP;
        if (bubbleCnt != 4'h0) begin
          bubbleCnt  <= bubbleCnt - 4'h1;
          fetchValid <= (bubbleCnt == 4'h1);
        end else begin
          fetchValid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_fetch_redirect_unit;
  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          INSTR_BYTES   = 4;
  localparam int          BUBBLE_CYCLES = 1;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        shouldBranch;
  logic [31:0] branchTarget;
  logic [31:0] programCounter;
  logic        fetchValid;
  logic        flushDecode;
  logic        flushExecute;
  logic        redirectPending;
  logic        misalignedTarget;
  logic [31:0] redirectCount;

  int checks = 0;
  int errors = 0;

  fetch_redirect_unit #(
    .RESET_PC(RESET_PC), .INSTR_BYTES(INSTR_BYTES), .BUBBLE_CYCLES(BUBBLE_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .shouldBranch(shouldBranch),
    .branchTarget(branchTarget), .programCounter(programCounter),
    .fetchValid(fetchValid), .flushDecode(flushDecode), .flushExecute(flushExecute),
    .redirectPending(redirectPending), .misalignedTarget(misalignedTarget),
    .redirectCount(redirectCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the fetch front end should look like after each edge.
  logic [31:0] mPc;
  logic        mHeld;
  logic [31:0] mHeldTgt;
  int          mBubblesLeft;
  logic        mValid;
  logic        mMis;
  logic [31:0] mCount;
  // Flush values seen just before the edge, and what the model wanted.
  logic        obsFlushD, obsFlushE, expFlush;

  task automatic model_reset();
    mPc = RESET_PC; mHeld = 1'b0; mHeldTgt = 32'h0; mBubblesLeft = 0;
    mValid = 1'b0; mMis = 1'b0; mCount = 32'h0;
  endtask

  // Drive one cycle's inputs (called just after a negedge), record the
  // combinational flushes, advance the model across the posedge and return
  // at the following negedge.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    logic want;
    logic [31:0] tgt;
    stall = s; shouldBranch = b; branchTarget = t;
    #1;
    obsFlushD = flushDecode;
    obsFlushE = flushExecute;
    want = b || mHeld;
    tgt  = b ? t : mHeldTgt;
    expFlush = want && !s;
    @(posedge clk);
    if (want && !s) begin
      mPc = tgt & 32'hFFFF_FFFC;
      mMis = (tgt % 4) != 0;
      mHeld = 1'b0;
      mCount = mCount + 1;
      mBubblesLeft = BUBBLE_CYCLES;
      mValid = 1'b0;
    end else begin
      mMis = 1'b0;
      if (s) begin
        if (b) begin
          mHeld = 1'b1;
          mHeldTgt = t;
        end
      end else begin
        mPc = mPc + INSTR_BYTES;
        if (mBubblesLeft > 0) begin
          mBubblesLeft = mBubblesLeft - 1;
          mValid = (mBubblesLeft == 0);
        end else begin
          mValid = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    stall = 1'b0; shouldBranch = 1'b0; branchTarget = 32'h0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (programCounter !== RESET_PC || fetchValid !== 1'b0 || redirectPending !== 1'b0 ||
        misalignedTarget !== 1'b0 || redirectCount !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: pc=%h fv=%b pend=%b mis=%b cnt=%0d, required pc=%h all others 0",
               programCounter, fetchValid, redirectPending, misalignedTarget, redirectCount, RESET_PC);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (programCounter !== 32'(4 * i) || fetchValid !== 1'b1 || redirectCount !== 32'h0) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: pc=%h fv=%b cnt=%0d, required pc=%h fv=1 cnt=0",
                 i, programCounter, fetchValid, redirectCount, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    step(1'b0, 1'b1, 32'h100);
    checks++;
    if (obsFlushD !== 1'b1 || obsFlushE !== 1'b1) begin
      errors++;
      $display("FAIL redirect_flush: flushD=%b flushE=%b, required 1 1", obsFlushD, obsFlushE);
    end
    checks++;
    if (programCounter !== 32'h100 || fetchValid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_apply: pc=%h fv=%b, required pc=00000100 fv=0", programCounter, fetchValid);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (programCounter !== 32'h104 || fetchValid !== 1'b1 || redirectCount !== 32'd1) begin
      errors++;
      $display("FAIL redirect_after: pc=%h fv=%b cnt=%0d, required pc=00000104 fv=1 cnt=1",
               programCounter, fetchValid, redirectCount);
    end
  endtask

  task automatic test_stall_defer();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i == 0, 32'h200);
      checks++;
      if (obsFlushD !== 1'b0 || obsFlushE !== 1'b0 || redirectPending !== 1'b1 ||
          programCounter !== 32'h104) begin
        errors++;
        $display("FAIL stall_hold[%0d]: flushD=%b flushE=%b pend=%b pc=%h, required 0 0 1 00000104",
                 i, obsFlushD, obsFlushE, redirectPending, programCounter);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (obsFlushD !== 1'b1 || obsFlushE !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_flush: flushD=%b flushE=%b, required 1 1", obsFlushD, obsFlushE);
    end
    checks++;
    if (programCounter !== 32'h200 || redirectPending !== 1'b0 || redirectCount !== 32'd2) begin
      errors++;
      $display("FAIL stall_release_pc: pc=%h pend=%b cnt=%0d, required 00000200 0 2",
               programCounter, redirectPending, redirectCount);
    end
  endtask

  task automatic test_newest_wins();
    step(1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h400);
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (programCounter !== 32'h400 || redirectCount !== 32'd3 || redirectPending !== 1'b0) begin
      errors++;
      $display("FAIL newest_wins: pc=%h cnt=%0d pend=%b, required 00000400 3 0",
               programCounter, redirectCount, redirectPending);
    end
  endtask

  task automatic test_misaligned_and_wrap();
    step(1'b0, 1'b1, 32'h502);
    checks++;
    if (programCounter !== 32'h500 || misalignedTarget !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_apply: pc=%h mis=%b, required 00000500 1", programCounter, misalignedTarget);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (misalignedTarget !== 1'b0 || programCounter !== 32'h504) begin
      errors++;
      $display("FAIL misaligned_pulse: mis=%b pc=%h, required 0 00000504", misalignedTarget, programCounter);
    end
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (programCounter !== 32'h0 || misalignedTarget !== 1'b0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h mis=%b, required 00000000 0", programCounter, misalignedTarget);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 32'h600);
    checks++;
    if (redirectPending !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_pending: pend=%b, required 1", redirectPending);
    end
    stall = 1'b1; shouldBranch = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (programCounter !== RESET_PC || redirectPending !== 1'b0 || fetchValid !== 1'b0 ||
        misalignedTarget !== 1'b0 || redirectCount !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: pc=%h pend=%b fv=%b mis=%b cnt=%0d, required pc=%h others 0",
               programCounter, redirectPending, fetchValid, misalignedTarget, redirectCount, RESET_PC);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (obsFlushD !== 1'b0 || programCounter !== RESET_PC + 32'd4 || fetchValid !== 1'b1 ||
        redirectCount !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: flushD=%b pc=%h fv=%b cnt=%0d, required 0 %h 1 0",
               obsFlushD, programCounter, fetchValid, redirectCount, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_random();
    logic s, b;
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 9) < 3);
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t = t & 32'h0000_0FFF;
      step(s, b, t);
      checks++;
      if (obsFlushD !== expFlush || obsFlushE !== expFlush) begin
        errors++;
        $display("FAIL rand_flush[%0d]: flushD=%b flushE=%b, required %b", i, obsFlushD, obsFlushE, expFlush);
      end
      checks++;
      if (programCounter !== mPc || fetchValid !== mValid || redirectPending !== mHeld ||
          misalignedTarget !== mMis || redirectCount !== mCount) begin
        errors++;
        $display("FAIL rand_state[%0d]: pc=%h fv=%b pend=%b mis=%b cnt=%0d, required %h %b %b %b %0d",
                 i, programCounter, fetchValid, redirectPending, misalignedTarget, redirectCount,
                 mPc, mValid, mHeld, mMis, mCount);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; shouldBranch = 1'b0; branchTarget = 32'h0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_redirect();
    test_stall_defer();
    test_newest_wins();
    test_misaligned_and_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
